// File: rtl/strip_pkg.sv
// strip_pkg
//   Shared definitions for the strip write path: arbiter FSM state encoding,
//   pixel and LED address widths, burst counter width, and an index-width helper.
package strip_pkg;

   localparam int unsigned PIXEL_W     = 24;
   localparam int unsigned LED_ADDR_W  = 9;
   localparam int unsigned BURST_CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;

   // Width of an index into n items (at least 1 bit).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/strip_rr_picker.sv
// strip_rr_picker
//   Combinational round-robin pick: returns the first set request searching
//   upward from last_i+1, wrapping to bit 0.
//   req_i       in  NUM_REQ  request vector
//   last_i      in  REQ_W    index of the most recent grant
//   pick_o      out NUM_REQ  one-hot winner (0 when no request)
//   pick_idx_o  out REQ_W    binary index of the winner
//   valid_o     out 1        some request is set
module strip_rr_picker
   import strip_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned REQ_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [REQ_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [REQ_W-1:0]   pick_idx_o,
   output logic               valid_o
);

   logic [NUM_REQ-1:0] upper;
   logic               found;

   // Requests above the last grant take priority; otherwise wrap to the lowest.
   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      found      = 1'b0;
      upper      = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         upper[j] = req_i[j] && (REQ_W'(j) > last_i);
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!found && upper[j]) begin
            found      = 1'b1;
            pick_o[j]  = 1'b1;
            pick_idx_o = REQ_W'(j);
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!found && req_i[j]) begin
            found      = 1'b1;
            pick_o[j]  = 1'b1;
            pick_idx_o = REQ_W'(j);
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/strip_write_arbiter.sv
// strip_write_arbiter
//   Round-robin arbiter sharing the pixel write path into the strip drivers.
//   Grants one requester for a burst of up to MAX_BURST pixels, forwards each
//   accepted pixel one cycle later with a one-hot strip strobe, and inserts a
//   one-cycle GAP after every burst.
//   Optional feature macro: ADDR_CHECK_EN (range-check LED addresses, sticky
//   addr_err_o); when undefined addresses pass unchecked and addr_err_o is 0.
//   pixel_clk_i          in   pixel clock
//   rst_n_i              in   async active-low reset
//   req_i/req_valid_i    in   per-requester request / pixel-valid
//   req_strip_i          in   packed strip index per requester
//   req_addr_i           in   packed LED address per requester
//   req_rgb_i            in   packed {r,g,b} per requester
//   grant_o              out  one-hot registered grant
//   req_ready_o          out  grant qualified by BURST state
//   led_address_o        out  forwarded LED address
//   pixel_r_o/g_o/b_o    out  forwarded colour
//   led_address_valid_o  out  one-hot per-strip write strobe
//   busy_o               out  arbiter not idle
//   addr_err_o           out  sticky out-of-range address flag
module strip_write_arbiter
   import strip_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 2,
   parameter  int unsigned NUM_STRIPS = 4,
   parameter  int unsigned LED_COUNT  = 300,
   parameter  int unsigned MAX_BURST  = 16,
   localparam int unsigned STRIP_W    = idx_w(NUM_STRIPS),
   localparam int unsigned REQ_W      = idx_w(NUM_REQ)
) (
   input  logic                             pixel_clk_i,
   input  logic                             rst_n_i,
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic [NUM_REQ-1:0]               req_valid_i,
   input  logic [NUM_REQ*STRIP_W-1:0]       req_strip_i,
   input  logic [NUM_REQ*LED_ADDR_W-1:0]    req_addr_i,
   input  logic [NUM_REQ*PIXEL_W-1:0]       req_rgb_i,
   output logic [NUM_REQ-1:0]               grant_o,
   output logic [NUM_REQ-1:0]               req_ready_o,
   output logic [LED_ADDR_W-1:0]            led_address_o,
   output logic [7:0]                       pixel_r_o,
   output logic [7:0]                       pixel_g_o,
   output logic [7:0]                       pixel_b_o,
   output logic [NUM_STRIPS-1:0]            led_address_valid_o,
   output logic                             busy_o,
   output logic                             addr_err_o
);

`ifdef ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   localparam logic [LED_ADDR_W:0]    ADDR_LIM = (LED_ADDR_W+1)'(LED_COUNT);
   localparam logic [BURST_CNT_W-1:0] MAX_B    = BURST_CNT_W'(MAX_BURST);

   arb_state_t                state_q, state_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [REQ_W-1:0]          last_q, last_d;
   logic [BURST_CNT_W-1:0]    cnt_q, cnt_d;
   logic [LED_ADDR_W-1:0]     addr_q, addr_d;
   logic [PIXEL_W-1:0]        rgb_q, rgb_d;
   logic [NUM_STRIPS-1:0]     strobe_q, strobe_d;
   logic                      err_q, err_d;

   logic [NUM_REQ-1:0]        pick;
   logic [REQ_W-1:0]          pick_idx;
   logic                      pick_valid;

   logic                      sel_req, sel_valid, accept, addr_ok;
   logic [STRIP_W-1:0]        sel_strip;
   logic [LED_ADDR_W-1:0]     sel_addr;
   logic [PIXEL_W-1:0]        sel_rgb;

   strip_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i      (req_i),
      .last_i     (last_q),
      .pick_o     (pick),
      .pick_idx_o (pick_idx),
      .valid_o    (pick_valid)
   );

   // Current granted requester's inputs, selected through the one-hot grant.
   always_comb begin
      sel_req   = |(req_i & grant_q);
      sel_valid = |(req_valid_i & grant_q);
      sel_strip = '0;
      sel_addr  = '0;
      sel_rgb   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            sel_strip = req_strip_i[k*STRIP_W +: STRIP_W];
            sel_addr  = req_addr_i[k*LED_ADDR_W +: LED_ADDR_W];
            sel_rgb   = req_rgb_i[k*PIXEL_W +: PIXEL_W];
         end
      end
   end

   assign accept  = (state_q == ST_BURST) && sel_req && sel_valid;
   assign addr_ok = !ADDR_CHECK || ({1'b0, sel_addr} < ADDR_LIM);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rgb_d    = rgb_q;
      strobe_d = '0;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d = pick;
               last_d  = pick_idx;
               cnt_d   = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (accept) begin
               cnt_d  = cnt_q + 1'b1;
               addr_d = sel_addr;
               rgb_d  = sel_rgb;
               // Strip indices >= NUM_STRIPS match no bit, so no strobe fires.
               for (int unsigned s = 0; s < NUM_STRIPS; s++) begin
                  if (addr_ok && (sel_strip == STRIP_W'(s))) strobe_d[s] = 1'b1;
               end
               if (!addr_ok) err_d = 1'b1;
            end
            // Releasing req ends the burst; so does the MAX_BURST-th pixel,
            // which is still forwarded.
            if (!sel_req || (accept && (cnt_q + 1'b1 == MAX_B))) begin
               state_d = ST_GAP;
               grant_d = '0;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         last_q   <= REQ_W'(NUM_REQ - 1);
         cnt_q    <= '0;
         addr_q   <= '0;
         rgb_q    <= '0;
         strobe_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rgb_q    <= rgb_d;
         strobe_q <= strobe_d;
         err_q    <= err_d;
      end
   end

   assign grant_o             = grant_q;
   assign req_ready_o         = grant_q & {NUM_REQ{state_q == ST_BURST}};
   assign led_address_o       = addr_q;
   assign pixel_r_o           = rgb_q[23:16];
   assign pixel_g_o           = rgb_q[15:8];
   assign pixel_b_o           = rgb_q[7:0];
   assign led_address_valid_o = strobe_q;
   assign busy_o              = (state_q != ST_IDLE);
   assign addr_err_o          = err_q;

endmodule
